// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory while holding the core in reset
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // One word more than the address space so that N == depth is still representable.
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t      state;
    state_t      nxt;
    logic [15:0] n;
    logic [16:0] idx;
    logic [1:0]  cnt;
    logic [23:0] lanes;
    logic        accept;
    logic [15:0] n_full;
    logic [16:0] idx_inc;

    assign accept  = in_valid & in_ready;
    assign n_full  = {in_data, n[7:0]};
    assign idx_inc = idx + 17'd1;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) nxt = S_LEN0;
            S_LEN0:  if (accept) nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (n_full == 16'd0)
                        nxt = S_DONE;
                    else if ({1'b0, n_full} > DEPTH)
                        nxt = S_ERR;
                    else
                        nxt = S_DATA;
                end
            end
            S_DATA:  if (accept && cnt == 2'd3) nxt = S_WRITE;
            S_WRITE: nxt = (idx_inc == {1'b0, n}) ? S_DONE : S_DATA;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            n         <= '0;
            idx       <= '0;
            cnt       <= '0;
            lanes     <= '0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt == S_LEN0) || (nxt == S_LEN1) || (nxt == S_DATA);
            busy     <= (nxt == S_LEN0) || (nxt == S_LEN1) || (nxt == S_DATA) || (nxt == S_WRITE);
            mem_we   <= (nxt == S_WRITE);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        core_rst <= 1'b1;
                        idx      <= '0;
                        cnt      <= '0;
                    end
                end
                S_LEN0: if (accept) n[7:0] <= in_data;
                S_LEN1: begin
                    if (accept) begin
                        n[15:8] <= in_data;
                        if (n_full == 16'd0) begin
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else if ({1'b0, n_full} > DEPTH) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        case (cnt)
                            2'd0: lanes[7:0]   <= in_data;
                            2'd1: lanes[15:8]  <= in_data;
                            2'd2: lanes[23:16] <= in_data;
                            default: begin
                                // Address and data are latched here so they stay stable through WRITE and after.
                                mem_addr  <= idx[ADDR_W-1:0];
                                mem_wdata <= {in_data, lanes};
                            end
                        endcase
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    idx <= idx_inc;
                    if (nxt == S_DONE) begin
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
